// File: rtl/escalonador_serial_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : escalonador_serial_if
//  Description : Bundle for the serial-TX scheduler: producer requests and
//                byte streams (tela, status), the TX byte handshake and the
//                packet completion / abort pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface escalonador_serial_if;
    logic       req_tela;
    logic [4:0] n_bytes_tela;
    logic [7:0] byte_tela;
    logic       prox_byte_tela;
    logic       req_status;
    logic [7:0] byte_status;
    logic       prox_byte_status;
    logic       tx_partida;
    logic [7:0] tx_dado;
    logic       tx_pronto;
    logic       ack_tela;
    logic       ack_status;
    logic       erro_tx;
    logic       ocupado;
    logic [3:0] db_estado;

    // Scheduler side
    modport slave (
        input  req_tela, n_bytes_tela, byte_tela,
        input  req_status, byte_status,
        input  tx_pronto,
        output prox_byte_tela, prox_byte_status,
        output tx_partida, tx_dado,
        output ack_tela, ack_status, erro_tx,
        output ocupado, db_estado
    );

    // Producers / TX side
    modport master (
        output req_tela, n_bytes_tela, byte_tela,
        output req_status, byte_status,
        output tx_pronto,
        input  prox_byte_tela, prox_byte_status,
        input  tx_partida, tx_dado,
        input  ack_tela, ack_status, erro_tx,
        input  ocupado, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/escalonador_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : escalonador_serial
//  Description : Round-robin arbiter between the frame renderer (tela) and the
//                status source sharing one serial transmitter. Frames each
//                grant as header + payload + XOR checksum and paces the bytes
//                through the tx_partida / tx_pronto handshake, aborting the
//                packet if the transmitter stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module escalonador_serial #(
    parameter int N_STATUS   = 4,
    parameter int TIMEOUT_TX = 20000
) (
    input  logic                clock,
    input  logic                reset,
    escalonador_serial_if.slave bus
);

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        CABECALHO  = 4'd1,
        ESPERA_CAB = 4'd2,
        PAYLOAD    = 4'd3,
        ESPERA_PAY = 4'd4,
        CHECKSUM   = 4'd5,
        ESPERA_CHK = 4'd6,
        FIM        = 4'd7
    } estado_t;

    localparam int                 C_CNT_W      = $clog2(TIMEOUT_TX) + 1;
    localparam logic [C_CNT_W-1:0] C_LIMITE     = C_CNT_W'(TIMEOUT_TX - 1);
    localparam logic [C_CNT_W-1:0] C_UM         = C_CNT_W'(1);
    localparam logic [4:0]         C_N_STATUS   = 5'(N_STATUS);
    localparam logic [2:0]         C_TAG_TELA   = 3'b101;
    localparam logic [2:0]         C_TAG_STATUS = 3'b110;

    estado_t            r_estado;
    estado_t            w_proximo;
    logic               r_grant_tela;      // 1: tela owns the link, 0: status
    logic               r_ultimo_status;   // last finished/aborted grant was status
    logic [4:0]         r_len;             // payload bytes still to send
    logic [7:0]         r_chk;             // running XOR of header and payload
    logic [7:0]         r_tx_dado;
    logic               r_tx_partida;
    logic               r_erro;
    logic [C_CNT_W-1:0] r_contador;        // cycles spent waiting on the current byte

    logic               w_req_any;
    logic               w_pick_tela;
    logic               w_espera;
    logic               w_timeout;
    logic [7:0]         w_header;
    logic [7:0]         w_byte;
    logic               w_prox_tela;
    logic               w_prox_status;
    logic               w_ack_tela;
    logic               w_ack_status;

    assign w_req_any   = bus.req_tela | bus.req_status;
    // On a tie the requester that did not go last wins
    assign w_pick_tela = bus.req_tela & (~bus.req_status | r_ultimo_status);
    assign w_espera    = (r_estado == ESPERA_CAB) | (r_estado == ESPERA_PAY) |
                         (r_estado == ESPERA_CHK);
    // A tx_pronto arriving on the last allowed cycle still counts as success
    assign w_timeout   = w_espera & ~bus.tx_pronto & (r_contador == C_LIMITE);
    // r_len holds N_STATUS for a status grant, so one concatenation covers both
    assign w_header    = {(r_grant_tela ? C_TAG_TELA : C_TAG_STATUS), r_len};
    assign w_byte      = r_grant_tela ? bus.byte_tela : bus.byte_status;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state decode plus the same-cycle consume/ack pulses
    always_comb begin
        w_proximo     = r_estado;
        w_prox_tela   = 1'b0;
        w_prox_status = 1'b0;
        w_ack_tela    = 1'b0;
        w_ack_status  = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (w_req_any) begin
                    w_proximo = CABECALHO;
                end
            end
            CABECALHO: w_proximo = ESPERA_CAB;
            ESPERA_CAB: begin
                if (bus.tx_pronto) begin
                    w_proximo = (r_len != 5'd0) ? PAYLOAD : CHECKSUM;
                end else if (w_timeout) begin
                    w_proximo = OCIOSO;
                end
            end
            PAYLOAD: w_proximo = ESPERA_PAY;
            ESPERA_PAY: begin
                if (bus.tx_pronto) begin
                    w_prox_tela   = r_grant_tela;
                    w_prox_status = ~r_grant_tela;
                    w_proximo     = (r_len > 5'd1) ? PAYLOAD : CHECKSUM;
                end else if (w_timeout) begin
                    w_proximo = OCIOSO;
                end
            end
            CHECKSUM: w_proximo = ESPERA_CHK;
            ESPERA_CHK: begin
                if (bus.tx_pronto) begin
                    w_proximo = FIM;
                end else if (w_timeout) begin
                    w_proximo = OCIOSO;
                end
            end
            FIM: begin
                w_ack_tela   = r_grant_tela;
                w_ack_status = ~r_grant_tela;
                w_proximo    = OCIOSO;
            end
            default: w_proximo = OCIOSO;
        endcase
    end

    // Grant/length latch, byte launch, checksum accumulation and stall timer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant_tela    <= 1'b0;
            r_ultimo_status <= 1'b1;
            r_len           <= 5'd0;
            r_chk           <= 8'd0;
            r_tx_dado       <= 8'd0;
            r_tx_partida    <= 1'b0;
            r_erro          <= 1'b0;
            r_contador      <= '0;
        end else begin
            r_tx_partida <= 1'b0;
            r_erro       <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_req_any) begin
                        r_grant_tela <= w_pick_tela;
                        r_len        <= w_pick_tela ? bus.n_bytes_tela : C_N_STATUS;
                        r_chk        <= 8'd0;
                    end
                end
                CABECALHO: begin
                    r_tx_partida <= 1'b1;
                    r_tx_dado    <= w_header;
                    r_chk        <= r_chk ^ w_header;
                    r_contador   <= '0;
                end
                PAYLOAD: begin
                    r_tx_partida <= 1'b1;
                    r_tx_dado    <= w_byte;
                    r_chk        <= r_chk ^ w_byte;
                    r_contador   <= '0;
                end
                CHECKSUM: begin
                    r_tx_partida <= 1'b1;
                    r_tx_dado    <= r_chk;
                    r_contador   <= '0;
                end
                ESPERA_CAB, ESPERA_PAY, ESPERA_CHK: begin
                    if (bus.tx_pronto) begin
                        if (r_estado == ESPERA_PAY) begin
                            r_len <= r_len - 5'd1;
                        end
                    end else if (w_timeout) begin
                        r_erro          <= 1'b1;
                        r_ultimo_status <= ~r_grant_tela;
                    end else begin
                        r_contador <= r_contador + C_UM;
                    end
                end
                FIM: begin
                    r_ultimo_status <= ~r_grant_tela;
                end
                default: begin
                    r_contador <= '0;
                end
            endcase
        end
    end

    assign bus.tx_partida       = r_tx_partida;
    assign bus.tx_dado          = r_tx_dado;
    assign bus.erro_tx          = r_erro;
    assign bus.prox_byte_tela   = w_prox_tela;
    assign bus.prox_byte_status = w_prox_status;
    assign bus.ack_tela         = w_ack_tela;
    assign bus.ack_status       = w_ack_status;
    assign bus.ocupado          = (r_estado != OCIOSO);
    assign bus.db_estado        = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_escalonador_serial
//  Description : Bench for escalonador_serial: directed packet scenarios plus
//                randomized request/length/payload/TX-latency mixes checked
//                against a packet-level model (header, payload, XOR checksum,
//                round-robin order).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_escalonador_serial;

    localparam int N_ST      = 4;
    localparam int C_TIMEOUT = 40;
    localparam int EV_T      = 1;
    localparam int EV_S      = 2;
    localparam int EV_E      = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    escalonador_serial_if bus ();

    escalonador_serial #(
        .N_STATUS   (N_ST),
        .TIMEOUT_TX (C_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         vectors     = 0;
    int         miscompares = 0;

    logic [7:0] mem_tela   [32];
    logic [7:0] mem_status [32];
    logic [4:0] idx_t;
    logic [4:0] idx_s;
    bit         tx_ativo = 1'b1;
    int         tx_delay = 5;
    logic       tx_busy;
    int         tx_cnt;

    logic [7:0] q_tx  [$];
    logic [7:0] q_exp [$];
    int         ev_code;
    int         n_prox_t;
    int         n_prox_s;
    int         first_tx_cyc;
    int         erro_cyc;
    logic       first_ocupado;
    logic [3:0] first_estado;
    bit         m_last_status;   // model of the round-robin pointer

    // Producers: present mem[idx], advance on consume, rewind per packet
    assign bus.byte_tela   = mem_tela[idx_t];
    assign bus.byte_status = mem_status[idx_s];
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_t <= 5'd0;
            idx_s <= 5'd0;
        end else begin
            if (bus.ack_tela || bus.erro_tx) idx_t <= 5'd0;
            else if (bus.prox_byte_tela) idx_t <= idx_t + 5'd1;
            if (bus.ack_status || bus.erro_tx) idx_s <= 5'd0;
            else if (bus.prox_byte_status) idx_s <= idx_s + 5'd1;
        end
    end

    // Serial transmitter model: tx_pronto a few cycles after each start
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_busy       <= 1'b0;
            tx_cnt        <= 0;
            bus.tx_pronto <= 1'b0;
        end else begin
            bus.tx_pronto <= 1'b0;
            if (bus.tx_partida && tx_ativo) begin
                tx_busy <= 1'b1;
                tx_cnt  <= tx_delay - 1;
            end else if (tx_busy) begin
                if (tx_cnt == 0) begin
                    bus.tx_pronto <= 1'b1;
                    tx_busy       <= 1'b0;
                end else begin
                    tx_cnt <= tx_cnt - 1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 5000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        m_last_status = 1'b1;
    endtask

    task automatic clear_obs();
        q_tx.delete();
        q_exp.delete();
        ev_code      = 0;
        n_prox_t     = 0;
        n_prox_s     = 0;
        first_tx_cyc = -1;
        erro_cyc     = -1;
    endtask

    // Reference packet: header, payload from producer memory, XOR of all of it
    function automatic void expect_packet(input bit tela, input int n);
        logic [7:0] h;
        logic [7:0] b;
        logic [7:0] chk;
        h = tela ? 8'(8'hA0 + n) : 8'(8'hC0 + N_ST);
        q_exp.push_back(h);
        chk = h;
        for (int i = 0; i < n; i++) begin
            b = tela ? mem_tela[5'(i)] : mem_status[5'(i)];
            q_exp.push_back(b);
            chk = chk ^ b;
        end
        q_exp.push_back(chk);
    endfunction

    // Watch the link until n_end packets have finished or aborted
    task automatic observe(input int n_end, input int max_cyc, input int drop_after_tx);
        int ends;
        int cyc;
        bit hdr_next;
        bit cur_tela;
        ends     = 0;
        cyc      = 0;
        hdr_next = 1'b1;
        cur_tela = 1'b0;
        while (ends < n_end && cyc < max_cyc) begin
            @(negedge clock);
            cyc++;
            if (bus.tx_partida) begin
                if (hdr_next) begin
                    cur_tela = (bus.tx_dado[7:5] == 3'b101);
                    hdr_next = 1'b0;
                    if (q_tx.size() == 0) begin
                        first_tx_cyc  = cyc;
                        first_ocupado = bus.ocupado;
                        first_estado  = bus.db_estado;
                    end
                end
                q_tx.push_back(bus.tx_dado);
                if (q_tx.size() == drop_after_tx) bus.req_tela = 1'b0;
            end
            if (bus.prox_byte_tela)   n_prox_t++;
            if (bus.prox_byte_status) n_prox_s++;
            if (bus.ack_tela) begin
                ev_code = ev_code * 4 + EV_T;
                bus.req_tela = 1'b0;
                ends++;
                hdr_next = 1'b1;
            end
            if (bus.ack_status) begin
                ev_code = ev_code * 4 + EV_S;
                bus.req_status = 1'b0;
                ends++;
                hdr_next = 1'b1;
            end
            if (bus.erro_tx) begin
                ev_code  = ev_code * 4 + EV_E;
                erro_cyc = cyc;
                if (cur_tela) bus.req_tela = 1'b0;
                else          bus.req_status = 1'b0;
                tx_ativo = 1'b1;
                ends++;
                hdr_next = 1'b1;
            end
        end
        vectors++;
        if (ends != n_end) begin
            miscompares++;
            $display("FAIL wait_packets: %0d packets ended in %0d cycles, required %0d", ends, cyc, n_end);
        end
    endtask

    task automatic test_reset();
        bus.req_tela = 1'b1;
        idle(3);
        vectors++;
        if ({bus.tx_partida, bus.tx_dado, bus.ocupado, bus.db_estado} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: partida/dado/ocupado/estado=%h, required 0",
                     {bus.tx_partida, bus.tx_dado, bus.ocupado, bus.db_estado});
        end
        vectors++;
        if ({bus.prox_byte_tela, bus.prox_byte_status, bus.ack_tela, bus.ack_status, bus.erro_tx} !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_pulses: %b, required 00000",
                     {bus.prox_byte_tela, bus.prox_byte_status, bus.ack_tela, bus.ack_status, bus.erro_tx});
        end
        bus.req_tela = 1'b0;
        reset = 1'b1;
        m_last_status = 1'b1;
        idle(1);
        vectors++;
        if (bus.ocupado !== 1'b0 || bus.db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_release: ocupado=%b estado=%0d, required 0/0", bus.ocupado, bus.db_estado);
        end
    endtask

    task automatic test_basic();
        idle(3);
        clear_obs();
        mem_tela[0] = 8'h11;
        mem_tela[1] = 8'h22;
        mem_tela[2] = 8'h33;
        bus.n_bytes_tela = 5'd3;
        bus.req_tela = 1'b1;
        observe(1, 500, -1);
        expect_packet(1'b1, 3);
        m_last_status = 1'b0;
        vectors++;
        if (first_tx_cyc != 2) begin
            miscompares++;
            $display("FAIL basic_latency: first tx_partida after %0d edges, required 2", first_tx_cyc);
        end
        vectors++;
        if (first_ocupado !== 1'b1 || first_estado !== 4'd2) begin
            miscompares++;
            $display("FAIL basic_busy: ocupado=%b estado=%0d at header, required 1/2", first_ocupado, first_estado);
        end
        vectors++;
        if (q_tx.size() != q_exp.size()) begin
            miscompares++;
            $display("FAIL basic_count: %0d bytes sent, required %0d", q_tx.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                vectors++;
                if (q_tx[i] !== q_exp[i]) begin
                    miscompares++;
                    $display("FAIL basic_byte%0d: %h, required %h", i, q_tx[i], q_exp[i]);
                end
            end
            vectors++;
            if (q_tx[4] !== 8'hA3) begin
                miscompares++;
                $display("FAIL basic_checksum: %h, required a3", q_tx[4]);
            end
        end
        vectors++;
        if (n_prox_t != 3 || n_prox_s != 0 || ev_code != EV_T) begin
            miscompares++;
            $display("FAIL basic_handshake: prox_t=%0d prox_s=%0d ev=%0d, required 3/0/%0d",
                     n_prox_t, n_prox_s, ev_code, EV_T);
        end
    endtask

    task automatic test_tie();
        do_reset();
        idle(2);
        clear_obs();
        for (int i = 0; i < 32; i++) begin
            mem_tela[i]   = 8'($urandom);
            mem_status[i] = 8'($urandom);
        end
        bus.n_bytes_tela = 5'd2;
        bus.req_tela   = 1'b1;
        bus.req_status = 1'b1;
        observe(2, 2000, -1);
        expect_packet(1'b1, 2);
        expect_packet(1'b0, N_ST);
        m_last_status = 1'b1;
        vectors++;
        if (q_tx.size() != q_exp.size()) begin
            miscompares++;
            $display("FAIL tie_count: %0d bytes sent, required %0d", q_tx.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                vectors++;
                if (q_tx[i] !== q_exp[i]) begin
                    miscompares++;
                    $display("FAIL tie_byte%0d: %h, required %h", i, q_tx[i], q_exp[i]);
                end
            end
            vectors++;
            if (q_tx[4] !== 8'hC4) begin
                miscompares++;
                $display("FAIL tie_status_header: %h, required c4", q_tx[4]);
            end
        end
        vectors++;
        if (ev_code != EV_T * 4 + EV_S || n_prox_t != 2 || n_prox_s != N_ST) begin
            miscompares++;
            $display("FAIL tie_order: ev=%0d prox_t=%0d prox_s=%0d, required %0d/2/%0d",
                     ev_code, n_prox_t, n_prox_s, EV_T * 4 + EV_S, N_ST);
        end
    endtask

    task automatic test_timeout();
        idle(3);
        clear_obs();
        tx_ativo = 1'b0;
        bus.n_bytes_tela = 5'd3;
        bus.req_tela   = 1'b1;
        bus.req_status = 1'b1;
        observe(2, 2000, -1);
        q_exp.push_back(8'hA3);
        expect_packet(1'b0, N_ST);
        m_last_status = 1'b1;
        vectors++;
        if (erro_cyc - first_tx_cyc != C_TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout_delay: erro_tx %0d cycles after tx_partida, required %0d",
                     erro_cyc - first_tx_cyc, C_TIMEOUT);
        end
        vectors++;
        if (ev_code != EV_E * 4 + EV_S || n_prox_t != 0 || n_prox_s != N_ST) begin
            miscompares++;
            $display("FAIL timeout_events: ev=%0d prox_t=%0d prox_s=%0d, required %0d/0/%0d",
                     ev_code, n_prox_t, n_prox_s, EV_E * 4 + EV_S, N_ST);
        end
        vectors++;
        if (q_tx.size() != q_exp.size()) begin
            miscompares++;
            $display("FAIL timeout_count: %0d bytes sent, required %0d", q_tx.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                vectors++;
                if (q_tx[i] !== q_exp[i]) begin
                    miscompares++;
                    $display("FAIL timeout_byte%0d: %h, required %h", i, q_tx[i], q_exp[i]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        idle(3);
        clear_obs();
        bus.n_bytes_tela = 5'd0;
        bus.req_tela = 1'b1;
        observe(1, 500, -1);
        m_last_status = 1'b0;
        vectors++;
        if (q_tx.size() != 2) begin
            miscompares++;
            $display("FAIL zero_count: %0d bytes sent, required 2", q_tx.size());
        end else begin
            vectors++;
            if (q_tx[0] !== 8'hA0 || q_tx[1] !== 8'hA0) begin
                miscompares++;
                $display("FAIL zero_bytes: %h %h, required a0 a0", q_tx[0], q_tx[1]);
            end
        end
        vectors++;
        if (n_prox_t != 0 || ev_code != EV_T) begin
            miscompares++;
            $display("FAIL zero_handshake: prox_t=%0d ev=%0d, required 0/%0d", n_prox_t, ev_code, EV_T);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int cyc;
        idle(3);
        clear_obs();
        for (int i = 0; i < 5; i++) mem_tela[i] = 8'($urandom);
        bus.n_bytes_tela = 5'd5;
        bus.req_tela = 1'b1;
        seen = 0;
        cyc  = 0;
        while (seen < 3 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (bus.tx_partida) seen++;
        end
        vectors++;
        if (seen != 3) begin
            miscompares++;
            $display("FAIL rstmid_reach: %0d bytes started, required 3", seen);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.tx_partida, bus.tx_dado, bus.db_estado} !== 13'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: partida/dado/estado=%h, required 0",
                     {bus.tx_partida, bus.tx_dado, bus.db_estado});
        end
        vectors++;
        if ({bus.ocupado, bus.ack_tela, bus.erro_tx, bus.prox_byte_tela} !== 4'd0) begin
            miscompares++;
            $display("FAIL rstmid_flags: ocupado/ack/erro/prox=%b, required 0000",
                     {bus.ocupado, bus.ack_tela, bus.erro_tx, bus.prox_byte_tela});
        end
        idle(2);
        reset = 1'b1;
        m_last_status = 1'b1;
        clear_obs();
        observe(1, 500, -1);
        expect_packet(1'b1, 5);
        m_last_status = 1'b0;
        vectors++;
        if (q_tx.size() != q_exp.size()) begin
            miscompares++;
            $display("FAIL rstmid_count: %0d bytes sent, required %0d", q_tx.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                vectors++;
                if (q_tx[i] !== q_exp[i]) begin
                    miscompares++;
                    $display("FAIL rstmid_byte%0d: %h, required %h", i, q_tx[i], q_exp[i]);
                end
            end
        end
        vectors++;
        if (n_prox_t != 5 || ev_code != EV_T) begin
            miscompares++;
            $display("FAIL rstmid_handshake: prox_t=%0d ev=%0d, required 5/%0d", n_prox_t, ev_code, EV_T);
        end
    endtask

    task automatic test_drop_req();
        idle(3);
        clear_obs();
        for (int i = 0; i < 4; i++) mem_tela[i] = 8'($urandom);
        bus.n_bytes_tela = 5'd4;
        bus.req_tela = 1'b1;
        observe(1, 500, 2);
        expect_packet(1'b1, 4);
        m_last_status = 1'b0;
        vectors++;
        if (q_tx.size() != q_exp.size()) begin
            miscompares++;
            $display("FAIL drop_count: %0d bytes sent, required %0d", q_tx.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                vectors++;
                if (q_tx[i] !== q_exp[i]) begin
                    miscompares++;
                    $display("FAIL drop_byte%0d: %h, required %h", i, q_tx[i], q_exp[i]);
                end
            end
        end
        vectors++;
        if (n_prox_t != 4 || ev_code != EV_T) begin
            miscompares++;
            $display("FAIL drop_handshake: prox_t=%0d ev=%0d, required 4/%0d", n_prox_t, ev_code, EV_T);
        end
    endtask

    task automatic test_random();
        int  sel;
        bit  rt;
        bit  rs;
        bit  first_tela;
        int  n;
        int  ev_exp;
        for (int it = 0; it < 20; it++) begin
            idle(2);
            clear_obs();
            sel = $urandom_range(1, 3);
            rt  = sel[0];
            rs  = sel[1];
            n   = $urandom_range(0, 31);
            tx_delay = $urandom_range(1, 6);
            for (int i = 0; i < 32; i++) begin
                mem_tela[i]   = 8'($urandom);
                mem_status[i] = 8'($urandom);
            end
            first_tela = (rt && rs) ? m_last_status : rt;
            if (rt && rs) begin
                expect_packet(first_tela, first_tela ? n : N_ST);
                expect_packet(!first_tela, first_tela ? N_ST : n);
                ev_exp = first_tela ? (EV_T * 4 + EV_S) : (EV_S * 4 + EV_T);
                m_last_status = first_tela;
            end else begin
                expect_packet(rt, rt ? n : N_ST);
                ev_exp = rt ? EV_T : EV_S;
                m_last_status = !rt;
            end
            bus.n_bytes_tela = 5'(n);
            bus.req_tela   = rt;
            bus.req_status = rs;
            observe(int'(rt) + int'(rs), 2000, -1);
            vectors++;
            if (ev_code != ev_exp || n_prox_t != (rt ? n : 0) || n_prox_s != (rs ? N_ST : 0)) begin
                miscompares++;
                $display("FAIL rand%0d_order: ev=%0d prox_t=%0d prox_s=%0d, required %0d/%0d/%0d",
                         it, ev_code, n_prox_t, n_prox_s, ev_exp, rt ? n : 0, rs ? N_ST : 0);
            end
            vectors++;
            if (q_tx.size() != q_exp.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count: %0d bytes sent, required %0d", it, q_tx.size(), q_exp.size());
            end else begin
                for (int i = 0; i < q_exp.size(); i++) begin
                    vectors++;
                    if (q_tx[i] !== q_exp[i]) begin
                        miscompares++;
                        $display("FAIL rand%0d_byte%0d: %h, required %h", it, i, q_tx[i], q_exp[i]);
                    end
                end
            end
        end
        tx_delay = 5;
    endtask

    initial begin
        bus.req_tela     = 1'b0;
        bus.req_status   = 1'b0;
        bus.n_bytes_tela = 5'd0;
        for (int i = 0; i < 32; i++) begin
            mem_tela[i]   = 8'd0;
            mem_status[i] = 8'd0;
        end
        m_last_status = 1'b1;
        clear_obs();
        test_reset();
        test_basic();
        test_tie();
        test_timeout();
        test_zero_len();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
